// File: rtl/rotary_pkg.sv
// Shared quadrature encodings and the transition classifier used by the encoder front end.
package rotary_pkg;

  localparam logic [1:0] Q_11 = 2'b11;
  localparam logic [1:0] Q_10 = 2'b10;
  localparam logic [1:0] Q_00 = 2'b00;
  localparam logic [1:0] Q_01 = 2'b01;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2,
    DIR_ILL  = 2'd3
  } dir_e;

  // CW order is 11 -> 10 -> 00 -> 01 -> 11; anything flipping both bits is illegal.
  function automatic dir_e quad_dir(input logic [1:0] prev, input logic [1:0] next);
    logic [1:0] cw_next;
    case (prev)
      Q_11:    cw_next = Q_10;
      Q_10:    cw_next = Q_00;
      Q_00:    cw_next = Q_01;
      default: cw_next = Q_11;
    endcase
    if (prev == next) begin
      quad_dir = DIR_NONE;
    end else if ((prev ^ next) == 2'b11) begin
      quad_dir = DIR_ILL;
    end else if (next == cw_next) begin
      quad_dir = DIR_CW;
    end else begin
      quad_dir = DIR_CCW;
    end
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer; all state resets to idle-high.
module input_debounce #(
  parameter int unsigned DEB_LEN = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam logic [15:0] CntLast = 16'(DEB_LEN - 1);

  logic [1:0]  sync_q;
  logic        deb_q, deb_d;
  logic [15:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the output restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      deb_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o = deb_q;

endmodule

// File: rtl/rotary_quad_counter.sv
// Quadrature rotary-encoder front end: debounced inputs, full Gray-code decode, sub-step
// accumulator and a bounded wrap/saturate counter with preset-on-press driving the LEDs.
module rotary_quad_counter
  import rotary_pkg::*;
#(
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned DEB_LEN        = 16,
  parameter int unsigned EDGES_PER_STEP = 4,
  parameter bit          WRAP           = 1'b1,
  parameter int unsigned CNT_MIN        = 0,
  parameter int unsigned CNT_MAX        = (1 << CNT_W) - 1,
  parameter int unsigned CNT_PRESET     = 0,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic             Fg_Clk,
  input  logic             RESETn,
  input  logic             Rot_A,
  input  logic             Rot_B,
  input  logic             Rot_SW,
  output logic [CNT_W-1:0] oCount,
  output logic [CNT_W-1:0] oLED,
  output logic             oStep_Up,
  output logic             oStep_Dn,
  output logic             oErr
);

  localparam logic [CNT_W-1:0] MinVal    = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] MaxVal    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] PresetVal = CNT_W'(CNT_PRESET);
  localparam logic signed [3:0] UpLast   = 4'(EDGES_PER_STEP - 1);
  localparam logic signed [3:0] DnLast   = -UpLast;

  logic a_deb, b_deb, sw_deb;

  input_debounce #(.DEB_LEN(DEB_LEN)) u_deb_a (
    .clk_i  (Fg_Clk),
    .rst_ni (RESETn),
    .d_i    (Rot_A),
    .q_o    (a_deb)
  );

  input_debounce #(.DEB_LEN(DEB_LEN)) u_deb_b (
    .clk_i  (Fg_Clk),
    .rst_ni (RESETn),
    .d_i    (Rot_B),
    .q_o    (b_deb)
  );

  input_debounce #(.DEB_LEN(DEB_LEN)) u_deb_sw (
    .clk_i  (Fg_Clk),
    .rst_ni (RESETn),
    .d_i    (Rot_SW),
    .q_o    (sw_deb)
  );

  logic [1:0]        ab_prev_q;
  logic              sw_prev_q;
  logic signed [3:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              up_q, up_d, dn_q, dn_d, err_q, err_d;
  dir_e              dir;
  logic              press;

  always_comb begin
    dir     = quad_dir(ab_prev_q, {a_deb, b_deb});
    press   = sw_prev_q & ~sw_deb;
    acc_d   = acc_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    count_d = count_q;

    case (dir)
      DIR_CW: begin
        if (acc_q == UpLast) begin
          up_d  = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = acc_q + 4'sd1;
        end
      end
      DIR_CCW: begin
        if (acc_q == DnLast) begin
          dn_d  = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = acc_q - 4'sd1;
        end
      end
      DIR_ILL: begin
        err_d = 1'b1;
        acc_d = '0;
      end
      default: ;
    endcase

    if (up_d) begin
      if (count_q == MaxVal) count_d = WRAP ? MinVal : count_q;
      else                   count_d = count_q + 1'b1;
    end else if (dn_d) begin
      if (count_q == MinVal) count_d = WRAP ? MaxVal : count_q;
      else                   count_d = count_q - 1'b1;
    end

    // A press overrides any step decoded in the same cycle; the step pulse still fires.
    if (press) begin
      count_d = PresetVal;
      acc_d   = '0;
    end
  end

  always_ff @(posedge Fg_Clk or negedge RESETn) begin
    if (!RESETn) begin
      ab_prev_q <= Q_11;
      sw_prev_q <= 1'b1;
      acc_q     <= '0;
      count_q   <= PresetVal;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ab_prev_q <= {a_deb, b_deb};
      sw_prev_q <= sw_deb;
      acc_q     <= acc_d;
      count_q   <= count_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
    end
  end

  assign oCount   = count_q;
  assign oLED     = LED_ACTIVE_LOW ? ~count_q : count_q;
  assign oStep_Up = up_q;
  assign oStep_Dn = dn_q;
  assign oErr     = err_q;

endmodule

// File: tb/tb_rotary_quad_counter.sv
// Bench for rotary_quad_counter: a wrapping and a saturating instance share the pins and are
// checked every cycle against a sample-history behavioural model, plus literal expectations.
module tb_rotary_quad_counter;

  localparam int DL   = 4;
  localparam int EPS  = 4;
  localparam int MAXV = 63;

  logic clk    = 1'b0;
  logic RESETn = 1'b1;
  logic rot_a  = 1'b1;
  logic rot_b  = 1'b1;
  logic rot_sw = 1'b1;

  logic [5:0] cnt_w, led_w, cnt_s, led_s;
  logic       up_w, dn_w, err_w, up_s, dn_s, err_s;

  always #5 clk = ~clk;

  rotary_quad_counter #(
    .CNT_W(6), .DEB_LEN(DL), .EDGES_PER_STEP(EPS), .WRAP(1'b1),
    .CNT_MIN(0), .CNT_MAX(MAXV), .CNT_PRESET(0), .LED_ACTIVE_LOW(1'b1)
  ) dut_w (
    .Fg_Clk(clk), .RESETn(RESETn), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_SW(rot_sw),
    .oCount(cnt_w), .oLED(led_w), .oStep_Up(up_w), .oStep_Dn(dn_w), .oErr(err_w)
  );

  rotary_quad_counter #(
    .CNT_W(6), .DEB_LEN(DL), .EDGES_PER_STEP(EPS), .WRAP(1'b0),
    .CNT_MIN(0), .CNT_MAX(MAXV), .CNT_PRESET(0), .LED_ACTIVE_LOW(1'b1)
  ) dut_s (
    .Fg_Clk(clk), .RESETn(RESETn), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_SW(rot_sw),
    .oCount(cnt_s), .oLED(led_s), .oStep_Up(up_s), .oStep_Dn(dn_s), .oErr(err_s)
  );

  // ---------------- behavioural model ----------------
  logic [2:0] hist[$];   // pin samples {A,B,SW}, one per clock edge
  logic [2:0] m_deb;     // debounced {A,B,SW}
  logic [1:0] m_prev;
  logic       m_sw_last;
  int         m_acc, m_cnt_w, m_cnt_s;
  logic       m_up, m_dn, m_err;

  // Position of a phase state along the CW cycle 11,10,00,01.
  function automatic int qpos(input logic [1:0] s);
    case (s)
      2'b11:   qpos = 0;
      2'b10:   qpos = 1;
      2'b00:   qpos = 2;
      default: qpos = 3;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DL + 2; i++) hist.push_back(3'b111);
    m_deb = 3'b111; m_prev = 2'b11; m_sw_last = 1'b1;
    m_acc = 0; m_cnt_w = 0; m_cnt_s = 0;
    m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int d;
    int last;
    bit all_diff;
    m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
    if (m_deb[2:1] != m_prev) begin
      d = (qpos(m_deb[2:1]) - qpos(m_prev) + 4) % 4;
      if (d == 2) begin
        m_err = 1'b1; m_acc = 0;
      end else begin
        m_acc += (d == 1) ? 1 : -1;
        if (m_acc == EPS) begin m_up = 1'b1; m_acc = 0; end
        else if (m_acc == -EPS) begin m_dn = 1'b1; m_acc = 0; end
      end
      m_prev = m_deb[2:1];
    end
    if (m_up) begin
      m_cnt_w = (m_cnt_w == MAXV) ? 0 : m_cnt_w + 1;
      m_cnt_s = (m_cnt_s == MAXV) ? MAXV : m_cnt_s + 1;
    end else if (m_dn) begin
      m_cnt_w = (m_cnt_w == 0) ? MAXV : m_cnt_w - 1;
      m_cnt_s = (m_cnt_s == 0) ? 0 : m_cnt_s - 1;
    end
    if (m_sw_last && !m_deb[0]) begin
      m_cnt_w = 0; m_cnt_s = 0; m_acc = 0;
    end
    m_sw_last = m_deb[0];
    // The debouncer sees pins two edges late and flips after DL consecutive differing samples.
    last = hist.size() - 1;
    for (int k = 0; k < 3; k++) begin
      all_diff = 1'b1;
      for (int j = last - DL; j <= last - 1; j++) if (hist[j][k] == m_deb[k]) all_diff = 1'b0;
      if (all_diff) m_deb[k] = ~m_deb[k];
    end
    hist.push_back({rot_a, rot_b, rot_sw});
    void'(hist.pop_front());
  endtask

  always @(posedge clk or negedge RESETn) begin
    if (!RESETn) model_reset();
    else         model_step();
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;
  int n_up_w = 0, n_dn_w = 0, n_err_w = 0, n_up_s = 0, n_dn_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic monitor();
    logic [5:0] ew, es;
    forever begin
      @(negedge clk);
      if (RESETn) begin
        n_up_w += int'(up_w); n_dn_w += int'(dn_w); n_err_w += int'(err_w);
        n_up_s += int'(up_s); n_dn_s += int'(dn_s);
        ew = 6'(m_cnt_w);
        es = 6'(m_cnt_s);
        chk("cycle_wrap", 32'({cnt_w, led_w, up_w, dn_w, err_w}),
            32'({ew, ~ew, m_up, m_dn, m_err}));
        chk("cycle_sat", 32'({cnt_s, led_s, up_s, dn_s, err_s}),
            32'({es, ~es, m_up, m_dn, m_err}));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] ab = 2'b11;
  logic [1:0] cw_seq[4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  task automatic drive(input logic [1:0] v, input int hold);
    @(negedge clk);
    ab = v; rot_a = v[1]; rot_b = v[0];
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic set_sw(input logic v, input int hold);
    @(negedge clk);
    rot_sw = v;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic detent(input int dir, input int hold);
    for (int i = 0; i < 4; i++) drive(cw_seq[(qpos(ab) + dir + 4) % 4], hold);
  endtask

  initial begin
    int b_up, b_dn, b_err, b_us, b_ds, r, h;
    logic [1:0] keep;
    fork monitor(); join_none

    RESETn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_count", 32'(cnt_w), 32'd0);
    chk("reset_led", 32'(led_w), 32'h3F);
    chk("reset_pulses", 32'({up_w, dn_w, err_w, up_s, dn_s, err_s}), 32'd0);
    chk("reset_count_sat", 32'(cnt_s), 32'd0);
    RESETn = 1'b1;
    repeat (5) @(negedge clk);

    // Full CW detent, 10 cycles per phase
    b_up = n_up_w; b_dn = n_dn_w;
    detent(1, 10);
    chk("cw_count", 32'(cnt_w), 32'd1);
    chk("cw_led", 32'(led_w), 32'b111110);
    chk("cw_one_up", 32'(n_up_w - b_up), 32'd1);
    chk("cw_no_dn", 32'(n_dn_w - b_dn), 32'd0);

    // Bounce on A shorter than the debounce window
    b_up = n_up_w + n_dn_w + n_err_w;
    for (int i = 0; i < 10; i++) drive(ab ^ 2'b10, 2);
    drive(2'b11, 12);
    chk("bounce_no_pulse", 32'(n_up_w + n_dn_w + n_err_w - b_up), 32'd0);
    chk("bounce_count", 32'(cnt_w), 32'd1);

    // Half-detent reversal
    b_up = n_up_w + n_dn_w;
    drive(2'b10, 12); drive(2'b00, 12); drive(2'b10, 12); drive(2'b11, 12);
    chk("reversal_no_step", 32'(n_up_w + n_dn_w - b_up), 32'd0);
    chk("reversal_count", 32'(cnt_w), 32'd1);

    // Illegal 10 -> 01 jump, then legal CW motion
    b_err = n_err_w;
    drive(2'b10, 12); drive(2'b01, 12);
    chk("illegal_err", 32'(n_err_w - b_err), 32'd1);
    b_up = n_up_w;
    drive(2'b11, 12);
    detent(1, 12);
    chk("illegal_then_one_up", 32'(n_up_w - b_up), 32'd1);
    chk("illegal_count", 32'(cnt_w), 32'd2);

    // Press alone, then press coinciding with a step
    set_sw(1'b0, 12);
    chk("press_preset", 32'(cnt_w), 32'd0);
    set_sw(1'b1, 12);
    b_up = n_up_w;
    drive(2'b10, 12); drive(2'b00, 12); drive(2'b01, 12);
    @(negedge clk);
    ab = 2'b11; rot_a = 1'b1; rot_sw = 1'b0;
    repeat (11) @(negedge clk);
    chk("press_prio_up_pulse", 32'(n_up_w - b_up), 32'd1);
    chk("press_prio_count_w", 32'(cnt_w), 32'd0);
    chk("press_prio_count_s", 32'(cnt_s), 32'd0);
    set_sw(1'b1, 12);

    // Wrap versus saturate at both limits
    b_ds = n_dn_s;
    detent(-1, 12);
    chk("wrap_min_to_max", 32'(cnt_w), 32'd63);
    chk("sat_min_hold", 32'(cnt_s), 32'd0);
    chk("sat_min_pulse", 32'(n_dn_s - b_ds), 32'd1);
    detent(1, 12);
    chk("wrap_max_to_min", 32'(cnt_w), 32'd0);
    chk("sat_inc", 32'(cnt_s), 32'd1);
    repeat (62) detent(1, 12);
    chk("sat_at_max", 32'(cnt_s), 32'd63);
    b_us = n_up_s;
    detent(1, 12);
    chk("sat_max_hold", 32'(cnt_s), 32'd63);
    chk("sat_max_pulse", 32'(n_up_s - b_us), 32'd1);
    chk("wrap_count_63", 32'(cnt_w), 32'd63);

    // Randomised motion, glitches, illegal jumps and presses
    for (int it = 0; it < 1200; it++) begin
      r = $urandom_range(0, 9);
      h = $urandom_range(1, 10);
      if (r <= 2)      drive(cw_seq[(qpos(ab) + 1) % 4], h);
      else if (r <= 5) drive(cw_seq[(qpos(ab) + 3) % 4], h);
      else if (r == 6) drive(~ab, h);
      else if (r == 7) begin
        keep = ab;
        drive(keep ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01), $urandom_range(1, 3));
        drive(keep, h);
      end else set_sw(~rot_sw, h);
    end
    set_sw(1'b1, 2);
    drive(2'b11, 16);

    // Reset asserted mid-detent, then encoder resting at 00 after release
    drive(2'b10, 12);
    drive(2'b00, 3);
    #2 RESETn = 1'b0;
    #1;
    chk("midreset_count", 32'(cnt_w), 32'd0);
    chk("midreset_led", 32'(led_w), 32'h3F);
    chk("midreset_pulses", 32'({up_w, dn_w, err_w, up_s, dn_s, err_s}), 32'd0);
    chk("midreset_count_sat", 32'(cnt_s), 32'd0);
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    b_err = n_err_w; b_up = n_up_w + n_dn_w;
    repeat (12) @(negedge clk);
    chk("release_at_00_err", 32'(n_err_w - b_err), 32'd1);
    chk("release_at_00_no_step", 32'(n_up_w + n_dn_w - b_up), 32'd0);
    drive(2'b01, 12);
    drive(2'b11, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rotary_quad_counter.md
# rotary_quad_counter

Parametrised quadrature rotary-encoder front end for the Tang9k boards. It synchronises and debounces the A/B encoder phases and the push switch, then fully decodes the Gray-code sequence with configurable edges per detent. It drives a bounded up/down counter with wrap or saturate mode, a preset-on-press function, and the LED bank. It sits directly behind the encoder pins and supersedes the simple falling-edge up/down LED counter.

## Interface
- CNT_W, 6: counter and LED width
- DEB_LEN, 16: consecutive stable cycles required before a debounced input changes (1..65535)
- EDGES_PER_STEP, 4: valid quadrature transitions per count step (1, 2 or 4)
- WRAP, 1: 1 = wrap at limits, 0 = saturate
- CNT_MIN, 0 / CNT_MAX, 2^CNT_W-1 / CNT_PRESET, 0: counter bounds and reset/press value (CNT_MIN ≤ CNT_PRESET ≤ CNT_MAX)
- LED_ACTIVE_LOW, 1: invert oLED
- Fg_Clk  in  1  clock
- RESETn  in  1  reset, asynchronous, active-low
- Rot_A  in  1  encoder phase A, asynchronous, idle high
- Rot_B  in  1  encoder phase B, asynchronous, idle high
- Rot_SW  in  1  encoder push switch, asynchronous, active-low
- oCount  out  CNT_W  current count
- oLED  out  CNT_W  oCount, inverted when LED_ACTIVE_LOW=1
- oStep_Up  out  1  one-cycle pulse on each increment request
- oStep_Dn  out  1  one-cycle pulse on each decrement request
- oErr  out  1  one-cycle pulse on an illegal quadrature transition

## Operation
- Each of A, B and SW passes through a 2-flop synchroniser (reset 1), then a debouncer. The debounced output takes the new level only after the synchronised input differs from it for DEB_LEN consecutive cycles. Any bounce restarts the stability counter.
- Decoder holds the previous debounced {A,B}. On a change it classifies the transition:
  - CW (+1): 11→10→00→01→11
  - CCW (−1): reverse of the CW sequence
  - Illegal: both bits change in one update. This pulses oErr, clears the sub-step accumulator, and adopts the new state.
- Signed sub-step accumulator:
  - Reaching +EDGES_PER_STEP raises oStep_Up and clears the accumulator.
  - Reaching −EDGES_PER_STEP raises oStep_Dn and clears the accumulator.
  - A direction reversal mid-detent simply counts back toward 0, so no step is emitted.
- Counter:
  - On Up: if count==CNT_MAX, load CNT_MIN when WRAP=1, otherwise hold; else count+1.
  - On Dn: the mirror case. At CNT_MIN, load CNT_MAX when WRAP=1, otherwise hold.
  - A step pulse is still emitted when a saturated count holds.
- Debounced SW falling edge loads CNT_PRESET and clears the accumulator. It has priority over a step in the same cycle.
- Up and Dn cannot occur together, since at most one transition is decoded per cycle.

## Timing
- Reset values:
  - oCount = CNT_PRESET, oLED accordingly
  - oStep_Up = oStep_Dn = oErr = 0
  - Debounced A/B/SW = 1, accumulator = 0, stability counters = 0
- Latency:
  - Pin edge to debounced change: 2 sync cycles + DEB_LEN cycles.
  - Debounced change to step/err pulse: 1 cycle.
  - oCount and oLED update in the same cycle the step pulse is high (all registered together).
- Pulses are exactly one cycle wide. Consecutive transitions produce distinct pulses provided the debounced inputs change on distinct cycles.
- Reset asserted mid-rotation aborts all state immediately, and the counter returns to CNT_PRESET.
- After reset release, the first decoded transition is relative to 11. If the encoder rests at 00, the first change from 11 to 00 is reported as illegal (oErr) and no step is emitted.

## Structure
- Package rotary_pkg holds:
  - quadrature state constants (Q_11, Q_10, Q_00, Q_01)
  - direction encoding (DIR_NONE, DIR_CW, DIR_CCW, DIR_ILL)
  - a function mapping {prev, next} to a direction
- Sub-module input_debounce (parameter DEB_LEN, including the 2-flop sync) is instantiated three times, for A, B and SW.
- The top level contains the decoder, accumulator and counter. Target size is roughly 200 lines total.

## Test plan
- **Full CW detent:** CNT_W=6, EDGES_PER_STEP=4, DEB_LEN=4. Drive 11→10→00→01→11, each phase held 10 cycles → exactly one oStep_Up; oCount 0→1 in the same cycle; oLED=6'b111110.
- **Bounce rejection:** toggle A every 2 cycles for 20 cycles, then hold → no debounced change until 4 stable cycles; no spurious steps.
- **Wrap versus saturate:**
  - WRAP=1, count 63, one CW detent → 0.
  - WRAP=0, count 63 → holds 63 with oStep_Up pulsed.
  - WRAP=0, count 0 plus one CCW detent → holds 0.
- **Half-detent reversal:** 11→10→00→10→11 → accumulator returns to 0; no step pulse; count unchanged.
- **Illegal jump:** force debounced 10→01 → oErr one cycle; accumulator cleared; next legal CW detent yields exactly one increment.
- **Press priority and reset:**
  - SW press coinciding with a step → count = CNT_PRESET.
  - RESETn pulsed low mid-detent → all outputs return to reset values within the same cycle.
